// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: funct3 codes, FSM/error encodings and access-width decode for the LSU
package riscv_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_t;
  // log2 of the access size in bytes; the low two funct3 bits carry it
  function automatic logic [1:0] size_log2(input logic [2:0] f3);
    return f3[1:0];
  endfunction
  function automatic logic f3_legal(input logic [2:0] f3, input logic we, input logic wide);
    return we ? (f3 inside {F3_B, F3_H, F3_W} || (wide && f3 == F3_D))
              : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} || (wide && f3 inside {F3_D, F3_WU}));
  endfunction
endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: datapath request/response and memory-port signals of the load/store unit
interface riscv_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  localparam int NB = DATA_W / 8;
  localparam int MA_W = ADDR_W - $clog2(NB);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        err_code;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [MA_W-1:0]   mem_addr;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, err_code, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, err_code, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/riscv_lsu_align.sv
// lsu_align: byte-lane steering, byte enables and load sign/zero extension
module lsu_align import riscv_lsu_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);
  logic [1:0] sz;
  logic [NB-1:0] mask;
  logic [DATA_W-1:0] keep, sh;
  logic sgn;
  always_comb begin
    sz = size_log2(funct3);
    for (int i = 0; i < NB; i++) mask[i] = i < (1 << sz);
    for (int i = 0; i < DATA_W; i++) keep[i] = i < (8 << sz);
    be = mask << off;
    wdata_sh = (wdata & keep) << {off, 3'b000};
    sh = rdata >> {off, 3'b000};
    sgn = ~funct3[2] & (sz == 2'd0 ? sh[7] : sz == 2'd1 ? sh[15] : sz == 2'd2 ? sh[31] : sh[DATA_W-1]);
    rdata_ext = (sh & keep) | (~keep & {DATA_W{sgn}});
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit driving a variable-latency memory port with byte enables,
// reporting misalignment, illegal widths and memory timeouts as error codes
module riscv_lsu import riscv_lsu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  riscv_lsu_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  err_t err_q, err_dec;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, wdata_sh, rdata_ext;
  logic [NB-1:0] be;
  logic [CNT_W-1:0] cnt;
  logic [OFF_W-1:0] amask;
  logic timeout;
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3(f3_q),
    .off(addr_q[OFF_W-1:0]),
    .wdata(wdata_q),
    .rdata(bus.mem_rdata),
    .be(be),
    .wdata_sh(wdata_sh),
    .rdata_ext(rdata_ext)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    for (int i = 0; i < OFF_W; i++) amask[i] = i < int'(size_log2(bus.req_funct3));
    err_dec = !f3_legal(bus.req_funct3, bus.req_we, DATA_W == 64) ? ERR_ILLEGAL :
              (bus.req_addr[OFF_W-1:0] & amask) != '0 ? ERR_MISALIGN : ERR_OK;
    timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    state_nx = state == S_IDLE ? (bus.req_valid ? (err_dec == ERR_OK ? S_WAIT : S_RESP) : S_IDLE) :
               state == S_WAIT ? ((bus.mem_ack || timeout) ? S_RESP : S_WAIT) : S_IDLE;
  end
  // ack is checked before timeout so an ack on the final wait cycle still completes
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_q <= ERR_OK;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
    end else begin
      if (state == S_IDLE && bus.req_valid) begin
        we_q <= bus.req_we;
        f3_q <= bus.req_funct3;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q <= err_dec;
        rdata_q <= '0;
        cnt <= '0;
      end
      if (state == S_WAIT) begin
        cnt <= cnt + CNT_W'(1);
        if (bus.mem_ack) begin
          err_q <= ERR_OK;
          rdata_q <= we_q ? '0 : rdata_ext;
        end else if (timeout) err_q <= ERR_TIMEOUT;
      end
      if (state == S_RESP) cnt <= '0;
    end
  always_comb begin
    bus.req_ready = state == S_IDLE;
    bus.stall = state == S_WAIT || (state == S_IDLE && bus.req_valid);
    bus.mem_req = state == S_WAIT;
    bus.mem_we = state == S_WAIT && we_q;
    bus.mem_addr = state == S_WAIT ? addr_q[ADDR_W-1:OFF_W] : '0;
    bus.mem_be = state == S_WAIT ? be : '0;
    bus.mem_wdata = (state == S_WAIT && we_q) ? wdata_sh : '0;
    bus.resp_valid = state == S_RESP;
    bus.resp_rdata = state == S_RESP ? rdata_q : '0;
    bus.err_code = state == S_RESP ? err_q : ERR_OK;
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: byte-level reference model checked every cycle against 32- and 64-bit LSUs,
// exhaustive lane check of lsu_align, plus hand-computed expectations from the test plan
module tb_riscv_lsu;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0, sel = 1'b0, chk = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
  logic [2:0] req_f3 = '0;
  logic [8:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;
  int checks = 0, failures = 0;
  int n_stall, n_mreq, n_resp;
  logic [63:0] last_rdata, last_wdata;
  logic [8:0] last_maddr;
  logic [7:0] last_be;
  logic [1:0] last_err;
  riscv_lsu_if #(.DATA_W(32), .ADDR_W(9)) i32 ();
  riscv_lsu_if #(.DATA_W(64), .ADDR_W(9)) i64 ();
  riscv_lsu #(.DATA_W(32), .ADDR_W(9), .TIMEOUT_CYCLES(TO)) d32 (.clk(clk), .reset(reset), .bus(i32.slave));
  riscv_lsu #(.DATA_W(64), .ADDR_W(9), .TIMEOUT_CYCLES(TO)) d64 (.clk(clk), .reset(reset), .bus(i64.slave));
  assign i32.req_valid = req_valid & ~sel;
  assign i32.req_we = req_we;
  assign i32.req_funct3 = req_f3;
  assign i32.req_addr = req_addr;
  assign i32.req_wdata = req_wdata[31:0];
  assign i32.mem_ack = mem_ack & ~sel;
  assign i32.mem_rdata = mem_rdata[31:0];
  assign i64.req_valid = req_valid & sel;
  assign i64.req_we = req_we;
  assign i64.req_funct3 = req_f3;
  assign i64.req_addr = req_addr;
  assign i64.req_wdata = req_wdata;
  assign i64.mem_ack = mem_ack & sel;
  assign i64.mem_rdata = mem_rdata;
  logic o_rdy, o_stall, o_mreq, o_mwe, o_rv;
  logic [8:0] o_maddr;
  logic [7:0] o_be;
  logic [63:0] o_wdata, o_rdata;
  logic [1:0] o_err;
  assign o_rdy = sel ? i64.req_ready : i32.req_ready;
  assign o_stall = sel ? i64.stall : i32.stall;
  assign o_mreq = sel ? i64.mem_req : i32.mem_req;
  assign o_mwe = sel ? i64.mem_we : i32.mem_we;
  assign o_maddr = sel ? {3'b0, i64.mem_addr} : {2'b0, i32.mem_addr};
  assign o_be = sel ? i64.mem_be : {4'b0, i32.mem_be};
  assign o_wdata = sel ? i64.mem_wdata : {32'b0, i32.mem_wdata};
  assign o_rv = sel ? i64.resp_valid : i32.resp_valid;
  assign o_rdata = sel ? i64.resp_rdata : {32'b0, i32.resp_rdata};
  assign o_err = sel ? i64.err_code : i32.err_code;
  logic e_rdy, e_stall, e_mreq, e_mwe, e_rv;
  logic [8:0] e_maddr;
  logic [7:0] e_be;
  logic [63:0] e_wdata, e_rdata;
  logic [1:0] e_err;
  logic [2:0] a_f3, a_off;
  logic [63:0] a_wd, a_rd;
  logic [3:0] a32_be;
  logic [31:0] a32_wsh, a32_rx;
  logic [7:0] a64_be;
  logic [63:0] a64_wsh, a64_rx;
  lsu_align #(.DATA_W(32)) a32 (.funct3(a_f3), .off(a_off[1:0]), .wdata(a_wd[31:0]), .rdata(a_rd[31:0]),
                                .be(a32_be), .wdata_sh(a32_wsh), .rdata_ext(a32_rx));
  lsu_align #(.DATA_W(64)) a64 (.funct3(a_f3), .off(a_off), .wdata(a_wd), .rdata(a_rd),
                                .be(a64_be), .wdata_sh(a64_wsh), .rdata_ext(a64_rx));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int f3_size(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd4} ? 1 : f3 inside {3'd1, 3'd5} ? 2 : f3 inside {3'd2, 3'd6} ? 4 : 8;
  endfunction

  function automatic bit legal_m(input bit we, input logic [2:0] f3, input bit wide);
    if (we) return f3 inside {3'd0, 3'd1, 3'd2} || (wide && f3 == 3'd3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (wide && f3 inside {3'd3, 3'd6});
  endfunction

  // byte-at-a-time view of the access: which lanes it touches and where each byte lands
  task automatic model(input bit we, input logic [2:0] f3, input logic [8:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input int nb, output logic [1:0] err, output logic [8:0] wa,
                       output logic [7:0] be, output logic [63:0] wsh, output logic [63:0] rx);
    int sz, off;
    bit sg;
    sz = f3_size(f3);
    off = int'(addr) % nb;
    err = !legal_m(we, f3, nb == 8) ? 2'b10 : (off % sz != 0) ? 2'b01 : 2'b00;
    wa = 9'(int'(addr) / nb);
    be = '0;
    wsh = '0;
    rx = '0;
    for (int i = off; i < nb && i < off + sz; i++) begin
      be[i] = 1'b1;
      wsh[8*i +: 8] = wd[8*(i-off) +: 8];
    end
    for (int j = 0; j < sz && off + j < nb; j++) rx[8*j +: 8] = rd[8*(off+j) +: 8];
    sg = f3 inside {3'd0, 3'd1, 3'd2} && rx[8*sz-1];
    for (int j = sz; j < nb; j++) rx[8*j +: 8] = {8{sg}};
  endtask

  task automatic exp_idle();
    e_rdy = 1'b1; e_stall = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0;
    e_be = '0; e_wdata = '0; e_rv = 1'b0; e_rdata = '0; e_err = '0;
  endtask

  always @(negedge clk) if (chk) begin
    check("req_ready", o_rdy, e_rdy);
    check("stall", o_stall, e_stall);
    check("mem_req", o_mreq, e_mreq);
    check("mem_we", o_mwe, e_mwe);
    check("mem_addr", o_maddr, e_maddr);
    check("mem_be", o_be, e_be);
    check("mem_wdata", o_wdata, e_wdata);
    check("resp_valid", o_rv, e_rv);
    check("resp_rdata", o_rdata, e_rdata);
    check("err_code", o_err, e_err);
    n_stall += int'(o_stall);
    n_mreq += int'(o_mreq);
    n_resp += int'(o_rv);
    if (o_rv) begin last_rdata = o_rdata; last_err = o_err; end
    if (o_mreq) begin last_maddr = o_maddr; last_be = o_be; last_wdata = o_wdata; end
  end

  // ack_at: wait cycle (1-based) in which memory acks; 0 means never
  task automatic xact(input bit we, input logic [2:0] f3, input logic [8:0] addr, input logic [63:0] wd,
                      input int ack_at, input logic [63:0] rd);
    logic [1:0] err;
    logic [8:0] wa;
    logic [7:0] be;
    logic [63:0] wsh, rx;
    model(we, f3, addr, wd, rd, sel ? 8 : 4, err, wa, be, wsh, rx);
    n_stall = 0; n_mreq = 0; n_resp = 0;
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    exp_idle();
    e_stall = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (err == 2'b00)
      for (int k = 1; k <= TO; k++) begin
        e_rdy = 1'b0; e_stall = 1'b1; e_mreq = 1'b1; e_mwe = we; e_maddr = wa; e_be = be;
        e_wdata = we ? wsh : '0;
        mem_ack = k == ack_at;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (k == ack_at) break;
      end
    exp_idle();
    e_rdy = 1'b0;
    e_rv = 1'b1;
    e_err = err != 2'b00 ? err : (ack_at >= 1 && ack_at <= TO) ? 2'b00 : 2'b11;
    e_rdata = (e_err == 2'b00 && !we) ? rx : '0;
    @(posedge clk); #1;
    exp_idle();
  endtask

  initial begin
    logic [1:0] merr;
    logic [8:0] mwa;
    logic [7:0] mbe;
    logic [63:0] mwsh, mrx;
    exp_idle();
    @(posedge clk); #1;
    check("rst_req_ready", o_rdy, 1);
    check("rst_mem_req", o_mreq, 0);
    check("rst_resp_valid", o_rv, 0);
    check("rst_stall", o_stall, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk = 1'b1;
    @(posedge clk); #1;
    // test 1: SW with ack in the third wait cycle
    xact(1, 3'b010, 9'h008, 64'hDEADBEEF, 3, 0);
    check("t1_stall_cycles", n_stall, 4);
    check("t1_resp_count", n_resp, 1);
    check("t1_mem_addr", last_maddr, 2);
    check("t1_mem_be", last_be, 8'h0F);
    check("t1_mem_wdata", last_wdata, 64'hDEADBEEF);
    check("t1_err", last_err, 0);
    // test 2: byte/half loads with extension
    xact(0, 3'b000, 9'h005, 0, 1, 64'h0000_80FF);
    check("t2_lb", last_rdata, 64'hFFFFFF80);
    xact(0, 3'b100, 9'h005, 0, 1, 64'h0000_80FF);
    check("t2_lbu", last_rdata, 64'h00000080);
    xact(0, 3'b001, 9'h006, 0, 1, 64'h8001_0000);
    check("t2_lh", last_rdata, 64'hFFFF8001);
    xact(0, 3'b101, 9'h006, 0, 2, 64'h8001_0000);
    check("t2_lhu", last_rdata, 64'h00008001);
    // test 3: errors never reach memory
    xact(1, 3'b001, 9'h003, 64'h1234, 1, 0);
    check("t3_mis_err", last_err, 2'b01);
    check("t3_mis_nomem", n_mreq, 0);
    xact(0, 3'b011, 9'h008, 0, 1, 0);
    check("t3_ld32_err", last_err, 2'b10);
    xact(0, 3'b111, 9'h001, 0, 1, 0);
    check("t3_illegal_first", last_err, 2'b10);
    xact(1, 3'b100, 9'h000, 0, 1, 0);
    check("t3_sbu_err", last_err, 2'b10);
    // test 4: timeout, ack exactly at the timeout, then a normal SB
    xact(0, 3'b010, 9'h00C, 0, 0, 64'hFFFFFFFF);
    check("t4_mreq_cycles", n_mreq, TO);
    check("t4_err", last_err, 2'b11);
    check("t4_rdata", last_rdata, 0);
    xact(0, 3'b010, 9'h010, 0, TO, 64'h12345678);
    check("t4_edge_err", last_err, 2'b00);
    check("t4_edge_rdata", last_rdata, 64'h12345678);
    xact(1, 3'b000, 9'h00D, 64'hAB, 2, 0);
    check("t4_sb_be", last_be, 8'h02);
    check("t4_sb_wdata", last_wdata, 64'h0000AB00);
    check("t4_sb_addr", last_maddr, 3);
    // test 5: asynchronous reset in the middle of a wait
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 9'h020;
    exp_idle();
    e_stall = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk = 1'b0;
    check("t5_in_wait", o_mreq, 1);
    #1 reset = 1'b0;
    #1;
    check("t5_mem_req", o_mreq, 0);
    check("t5_stall", o_stall, 0);
    check("t5_req_ready", o_rdy, 1);
    check("t5_resp_valid", o_rv, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_idle();
    n_resp = 0;
    chk = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 64'hCAFEF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_resp", n_resp, 0);
    // test 6: 64-bit datapath
    sel = 1'b1;
    @(posedge clk); #1;
    xact(1, 3'b011, 9'h010, 64'h1122334455667788, 1, 0);
    check("t6_sd_be", last_be, 8'hFF);
    check("t6_sd_addr", last_maddr, 2);
    xact(0, 3'b110, 9'h014, 0, 2, 64'hF000_0001_1234_5678);
    check("t6_lwu", last_rdata, 64'h00000000F0000001);
    xact(0, 3'b010, 9'h014, 0, 1, 64'hF000_0001_1234_5678);
    check("t6_lw", last_rdata, 64'hFFFFFFFFF0000001);
    xact(1, 3'b000, 9'h017, 64'h5A, 1, 0);
    check("t6_sb_be", last_be, 8'h80);
    check("t6_sb_wdata", last_wdata, 64'h5A00_0000_0000_0000);
    xact(0, 3'b010, 9'h012, 0, 1, 0);
    check("t6_mis_err", last_err, 2'b01);
    xact(0, 3'b011, 9'h008, 0, 0, 0);
    check("t6_ld_timeout", last_err, 2'b11);
    chk = 1'b0;
    // lsu_align exhaustive over offset x funct3, two data patterns, both widths
    for (int w = 0; w < 2; w++)
      for (int p = 0; p < 2; p++)
        for (int o = 0; o < 4 + 4 * w; o++)
          for (int f = 0; f < 8; f++) begin
            if (f3_size(3'(f)) > 4 + 4 * w) continue;
            a_f3 = 3'(f);
            a_off = 3'(o);
            a_wd = p != 0 ? 64'h0123_4567_89AB_CDEF : 64'hFEDC_BA98_7654_3210;
            a_rd = p != 0 ? 64'h8081_7F02_F0E1_00C3 : 64'h7F7E_80FD_0F1E_FF3C;
            #1;
            model(1'b0, a_f3, 9'(o), a_wd, a_rd, 4 + 4 * w, merr, mwa, mbe, mwsh, mrx);
            check("align_be", w != 0 ? {56'b0, a64_be} : {60'b0, a32_be}, {56'b0, mbe});
            check("align_wdata", w != 0 ? a64_wsh : {32'b0, a32_wsh}, mwsh);
            check("align_rdata", w != 0 ? a64_rx : {32'b0, a32_rx}, mrx);
          end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
